// File: rtl/pwr_dom_seq.sv
// Power-domain sequencer: walks isolation, clocks, retention, reset and the power
// switch of one switchable domain through a fixed safe order under a req/ack handshake.
module pwr_dom_seq #(
    parameter int SETTLE_W = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pwr_req_i,
    output logic                pwr_ack_o,
    input  logic [SETTLE_W-1:0] settle_i,
    output logic                sw_en_o,
    input  logic                sw_ack_i,
    output logic                iso_en_o,
    output logic                clk_en_o,
    output logic                dom_rst_no,
    output logic                ret_save_o,
    output logic                ret_restore_o,
    output logic                err_o,
    input  logic                err_clr_i,
    output logic [3:0]          state_o
);

    typedef enum logic [3:0] {
        S_OFF     = 4'd0,
        S_SW_ON   = 4'd1,
        S_SETTLE  = 4'd2,
        S_CLK_ON  = 4'd3,
        S_RST_REL = 4'd4,
        S_RESTORE = 4'd5,
        S_ISO_OFF = 4'd6,
        S_ON      = 4'd7,
        S_ISO_ON  = 4'd8,
        S_CLK_OFF = 4'd9,
        S_SAVE    = 4'd10,
        S_RST_ON  = 4'd11,
        S_SW_OFF  = 4'd12,
        S_ERR     = 4'd13
    } state_t;

    // The wait counter only has to reach TIMEOUT-1, so log2(TIMEOUT) bits suffice.
    localparam int                CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic                r_ret_valid;
    logic                r_pwr_ack;
    logic                r_sw_en;
    logic                r_iso_en;
    logic                r_clk_en;
    logic                r_dom_rst_n;
    logic                r_ret_save;
    logic                r_ret_restore;
    logic                r_err;

    logic                w_ack;
    logic                w_wait_st;
    logic                w_ack_match;
    logic                w_go_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sw_ack_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ack       = r_sync2;
    assign w_wait_st   = (r_state == S_SW_ON) || (r_state == S_SW_OFF);
    assign w_ack_match = (r_state == S_SW_ON) ? w_ack : ~w_ack;
    // Illegal encodings are treated like a switch failure: clamp everything and report.
    assign w_go_err    = (w_wait_st && !w_ack_match && (r_wait_cnt == WAIT_LAST))
                         || (r_state > S_ERR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_OFF;
            r_wait_cnt    <= '0;
            r_settle_cnt  <= '0;
            r_ret_valid   <= 1'b0;
            r_pwr_ack     <= 1'b0;
            r_sw_en       <= 1'b0;
            r_iso_en      <= 1'b1;
            r_clk_en      <= 1'b0;
            r_dom_rst_n   <= 1'b0;
            r_ret_save    <= 1'b0;
            r_ret_restore <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_ret_save    <= 1'b0;
            r_ret_restore <= 1'b0;
            if (w_go_err) begin
                r_state     <= S_ERR;
                r_err       <= 1'b1;
                r_iso_en    <= 1'b1;
                r_clk_en    <= 1'b0;
                r_dom_rst_n <= 1'b0;
                r_sw_en     <= 1'b0;
                r_pwr_ack   <= 1'b0;
                r_ret_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_OFF: begin
                        if (pwr_req_i) begin
                            r_state    <= S_SW_ON;
                            r_sw_en    <= 1'b1;
                            r_wait_cnt <= '0;
                        end
                    end
                    S_SW_ON: begin
                        if (w_ack) begin
                            r_state      <= S_SETTLE;
                            r_settle_cnt <= settle_i;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        end
                    end
                    // A settle value of 0 or 1 both leave after a single cycle.
                    S_SETTLE: begin
                        if (r_settle_cnt <= SETTLE_W'(1)) begin
                            r_state  <= S_CLK_ON;
                            r_clk_en <= 1'b1;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
                        end
                    end
                    S_CLK_ON: begin
                        r_state     <= S_RST_REL;
                        r_dom_rst_n <= 1'b1;
                    end
                    S_RST_REL: begin
                        r_state       <= S_RESTORE;
                        r_ret_restore <= r_ret_valid;
                        r_ret_valid   <= 1'b0;
                    end
                    S_RESTORE: begin
                        r_state  <= S_ISO_OFF;
                        r_iso_en <= 1'b0;
                    end
                    S_ISO_OFF: begin
                        r_state   <= S_ON;
                        r_pwr_ack <= 1'b1;
                    end
                    S_ON: begin
                        if (!pwr_req_i) begin
                            r_state   <= S_ISO_ON;
                            r_iso_en  <= 1'b1;
                            r_pwr_ack <= 1'b0;
                        end
                    end
                    S_ISO_ON: begin
                        r_state  <= S_CLK_OFF;
                        r_clk_en <= 1'b0;
                    end
                    S_CLK_OFF: begin
                        r_state     <= S_SAVE;
                        r_ret_save  <= 1'b1;
                        r_ret_valid <= 1'b1;
                    end
                    S_SAVE: begin
                        r_state     <= S_RST_ON;
                        r_dom_rst_n <= 1'b0;
                    end
                    S_RST_ON: begin
                        r_state    <= S_SW_OFF;
                        r_sw_en    <= 1'b0;
                        r_wait_cnt <= '0;
                    end
                    S_SW_OFF: begin
                        if (!w_ack) begin
                            r_state <= S_OFF;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        end
                    end
                    S_ERR: begin
                        if (err_clr_i) begin
                            r_state <= S_OFF;
                            r_err   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_ERR;
                    end
                endcase
            end
        end
    end

    assign pwr_ack_o     = r_pwr_ack;
    assign sw_en_o       = r_sw_en;
    assign iso_en_o      = r_iso_en;
    assign clk_en_o      = r_clk_en;
    assign dom_rst_no    = r_dom_rst_n;
    assign ret_save_o    = r_ret_save;
    assign ret_restore_o = r_ret_restore;
    assign err_o         = r_err;
    assign state_o       = r_state;

endmodule

// File: tb/tb_pwr_dom_seq.sv
// Directed bench for pwr_dom_seq: power-up/down order, retention pulses,
// mid-sequence request changes, switch timeout, async reset and the settle boundary.
module tb_pwr_dom_seq;

    localparam int TIMEOUT = 16;

    logic       clk      = 1'b0;
    logic       rstN     = 1'b0;
    logic       pwrReq   = 1'b0;
    logic       errClr   = 1'b0;
    logic [7:0] settle   = 8'd0;
    logic       swAck;
    logic       pwrAck;
    logic       swEn;
    logic       isoEn;
    logic       clkEn;
    logic       domRstN;
    logic       retSave;
    logic       retRestore;
    logic       errFlag;
    logic [3:0] state;

    logic       ackTrack = 1'b1;
    logic       lag1     = 1'b0;
    logic       lag2     = 1'b0;
    logic       prevClk  = 1'b0;
    logic       prevRst  = 1'b0;
    logic       prevSw   = 1'b0;

    int testsRun      = 0;
    int testsFailed   = 0;
    int savePulses    = 0;
    int restorePulses = 0;
    int isoViolations = 0;

    pwr_dom_seq #(.SETTLE_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .pwr_req_i    (pwrReq),
        .pwr_ack_o    (pwrAck),
        .settle_i     (settle),
        .sw_en_o      (swEn),
        .sw_ack_i     (swAck),
        .iso_en_o     (isoEn),
        .clk_en_o     (clkEn),
        .dom_rst_no   (domRstN),
        .ret_save_o   (retSave),
        .ret_restore_o(retRestore),
        .err_o        (errFlag),
        .err_clr_i    (errClr),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    // Switch chain model: the end-of-chain ack follows sw_en two cycles late.
    always @(posedge clk) begin
        lag1 <= swEn;
        lag2 <= lag1;
    end
    assign swAck = ackTrack & lag2;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [7:0] settleVal, input logic clr);
        pwrReq = req;
        settle = settleVal;
        errClr = clr;
    endtask

    // One clock; sample at the falling edge and track pulses and isolation ordering.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
        if (retSave === 1'b1) savePulses++;
        if (retRestore === 1'b1) restorePulses++;
        if (isoEn !== 1'b1 && (clkEn !== prevClk || domRstN !== prevRst || swEn !== prevSw))
            isoViolations++;
        prevClk = clkEn;
        prevRst = domRstN;
        prevSw  = swEn;
    endtask

    function automatic logic [4:0] ctlNow();
        return {swEn, clkEn, domRstN, isoEn, pwrAck};
    endfunction

    // Control vector is {sw_en, clk_en, dom_rst_n, iso_en, pwr_ack}.
    task automatic runPowerUp(input logic [7:0] settleVal, input logic expRestore, input int dropAt);
        int         len;
        int         base;
        logic [3:0] expState;
        logic [4:0] expCtl;
        len  = (settleVal == 8'd0) ? 1 : int'(settleVal);
        base = 5 + len;
        applyStimulus(1'b1, settleVal, 1'b0);
        for (int k = 0; k <= base + 4; k++) begin
            stepCycle();
            if (k < 5)         expState = 4'd1;
            else if (k < base) expState = 4'd2;
            else               expState = 4'(k - base + 3);
            if (k < base)            expCtl = 5'b10010;
            else if (k == base)      expCtl = 5'b11010;
            else if (k <= base + 2)  expCtl = 5'b11110;
            else if (k == base + 3)  expCtl = 5'b11100;
            else                     expCtl = 5'b11101;
            checkOutput($sformatf("up s%0d state c%0d", settleVal, k), 32'(state), 32'(expState));
            checkOutput($sformatf("up s%0d ctl c%0d", settleVal, k), 32'(ctlNow()), 32'(expCtl));
            if (k == base + 2)
                checkOutput($sformatf("up s%0d restore", settleVal), 32'(retRestore), 32'(expRestore));
            if (k == dropAt)
                applyStimulus(1'b0, settleVal, 1'b0);
        end
    endtask

    task automatic runPowerDown();
        logic [3:0] expState;
        logic [4:0] expCtl;
        applyStimulus(1'b0, settle, 1'b0);
        for (int k = 0; k <= 9; k++) begin
            stepCycle();
            if (k < 4)      expState = 4'(8 + k);
            else if (k < 9) expState = 4'd12;
            else            expState = 4'd0;
            if (k == 0)      expCtl = 5'b11110;
            else if (k <= 2) expCtl = 5'b10110;
            else if (k == 3) expCtl = 5'b10010;
            else             expCtl = 5'b00010;
            checkOutput($sformatf("down state c%0d", k), 32'(state), 32'(expState));
            checkOutput($sformatf("down ctl c%0d", k), 32'(ctlNow()), 32'(expCtl));
            if (k == 2)
                checkOutput("down save pulse", 32'(retSave), 32'd1);
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b0, 8'd3, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset outputs", 32'({isoEn, swEn, clkEn, domRstN, pwrAck, retSave, retRestore, errFlag}),
                    32'h80);
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) stepCycle();
        checkOutput("idle stays off", 32'(state), 32'd0);

        // Cold power-up: no retention yet
        runPowerUp(8'd3, 1'b0, -1);
        checkOutput("cold restore count", 32'(restorePulses), 32'd0);

        // Down then up: one save, then one restore
        runPowerDown();
        runPowerUp(8'd3, 1'b1, -1);
        checkOutput("save count 1", 32'(savePulses), 32'd1);
        checkOutput("restore count 1", 32'(restorePulses), 32'd1);

        // Request dropped during SETTLE: sequence completes, ON for one cycle, then down
        runPowerDown();
        runPowerUp(8'd3, 1'b1, 5);
        runPowerDown();

        // Settle of zero behaves like one
        runPowerUp(8'd0, 1'b1, -1);
        runPowerDown();

        // Switch timeout: ack never arrives
        ackTrack = 1'b0;
        applyStimulus(1'b1, 8'd3, 1'b0);
        for (int k = 0; k <= TIMEOUT; k++) begin
            stepCycle();
            if (k == 0)           checkOutput("to sw_on entry", 32'(state), 32'd1);
            if (k == TIMEOUT - 1) checkOutput("to still waiting", 32'(state), 32'd1);
        end
        checkOutput("to err state", 32'(state), 32'd13);
        checkOutput("to err flag", 32'(errFlag), 32'd1);
        checkOutput("to err ctl", 32'(ctlNow()), 32'b00010);
        for (int i = 0; i < 3; i++) stepCycle();
        checkOutput("err holds", 32'({state, errFlag}), 32'({4'd13, 1'b1}));
        applyStimulus(1'b0, 8'd3, 1'b1);
        stepCycle();
        checkOutput("err clr state", 32'(state), 32'd0);
        checkOutput("err clr flag", 32'(errFlag), 32'd0);
        applyStimulus(1'b0, 8'd3, 1'b0);
        ackTrack = 1'b1;
        stepCycle();
        runPowerUp(8'd3, 1'b0, -1);

        // err_clr outside ERR has no effect
        applyStimulus(1'b1, 8'd3, 1'b1);
        stepCycle();
        checkOutput("clr ignored in on", 32'({state, errFlag}), 32'({4'd7, 1'b0}));
        applyStimulus(1'b1, 8'd3, 1'b0);

        // Async reset while ON: outputs reset without a clock edge
        #2;
        rstN = 1'b0;
        applyStimulus(1'b0, 8'd3, 1'b0);
        #1;
        checkOutput("async rst state", 32'(state), 32'd0);
        checkOutput("async rst outputs", 32'({isoEn, swEn, clkEn, domRstN, pwrAck, retSave, retRestore, errFlag}),
                    32'h80);
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) stepCycle();
        checkOutput("post rst off", 32'(state), 32'd0);
        runPowerUp(8'd3, 1'b0, -1);

        // Reset after a save discards retention
        runPowerDown();
        #2;
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) stepCycle();
        runPowerUp(8'd3, 1'b0, -1);

        checkOutput("total saves", 32'(savePulses), 32'd5);
        checkOutput("total restores", 32'(restorePulses), 32'd3);
        checkOutput("iso ordering", 32'(isoViolations), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
